// File: rtl/vc_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vc_arbiter_pkg
//   Shared definitions for the virtual-channel transmit scheduler:
//   - arb_state_t : FSM state encoding (IDLE, ARB, WAIT)
//   - DEFAULT_DATA_WIDTH / DEFAULT_DEST_BIT : word layout shared with the
//     VC FIFOs, so both sides agree on width and routing-bit position.
//   - WEIGHT_CNT_WIDTH : width of the VC0 weighting counter.
// ---------------------------------------------------------------------------
package vc_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 6;
  localparam int DEFAULT_DEST_BIT   = 4;
  localparam int WEIGHT_CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

endpackage : vc_arbiter_pkg

// File: rtl/vc_arb_select.sv
// ---------------------------------------------------------------------------
// vc_arb_select
//   Purely combinational eligibility and grant logic for vc_arbiter.
//
//   Ports:
//     vc0_empty, vc1_empty         in  VC FIFO empty flags
//     vc0_head, vc1_head           in  VC FIFO head words
//     d0_almost_full, d1_almost_full in destination back-pressure flags
//     weight_cnt                   in  consecutive VC0 grants while VC1 waited
//     grant_vc0, grant_vc1         out one-hot (or zero) grant decision
//     grant_dest                   out destination of the granted word
//     grant_data                   out granted head word (0 when no grant)
//     next_weight_cnt              out weight_cnt value to load if granted
// ---------------------------------------------------------------------------
module vc_arb_select
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEST_BIT   = DEFAULT_DEST_BIT,
  parameter int WEIGHT     = 3
) (
  input  logic                        vc0_empty,
  input  logic                        vc1_empty,
  input  logic [DATA_WIDTH-1:0]       vc0_head,
  input  logic [DATA_WIDTH-1:0]       vc1_head,
  input  logic                        d0_almost_full,
  input  logic                        d1_almost_full,
  input  logic [WEIGHT_CNT_WIDTH-1:0] weight_cnt,
  output logic                        grant_vc0,
  output logic                        grant_vc1,
  output logic                        grant_dest,
  output logic [DATA_WIDTH-1:0]       grant_data,
  output logic [WEIGHT_CNT_WIDTH-1:0] next_weight_cnt
);

  localparam logic [WEIGHT_CNT_WIDTH-1:0] WEIGHT_C = WEIGHT_CNT_WIDTH'(WEIGHT);

  logic vc0_dest;
  logic vc1_dest;
  logic vc0_eligible;
  logic vc1_eligible;

  assign vc0_dest = vc0_head[DEST_BIT];
  assign vc1_dest = vc1_head[DEST_BIT];

  // A VC is skipped only when its own destination is full, so a blocked VC
  // never stalls the other one.
  assign vc0_eligible = !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
  assign vc1_eligible = !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);

  // NOTE: every output gets a default at the top of the block, so no path
  // through the if/else chain can leave one unassigned and infer a latch.
  always_comb begin
    grant_vc0       = 1'b0;
    grant_vc1       = 1'b0;
    grant_dest      = 1'b0;
    grant_data      = '0;
    next_weight_cnt = weight_cnt;

    if (vc0_eligible && vc1_eligible) begin
      // Both compete: VC0 keeps winning until it has used its weight.
      if (weight_cnt < WEIGHT_C) grant_vc0 = 1'b1;
      else                       grant_vc1 = 1'b1;
    end else if (vc0_eligible) begin
      grant_vc0 = 1'b1;
    end else if (vc1_eligible) begin
      grant_vc1 = 1'b1;
    end

    if (grant_vc0) begin
      grant_dest = vc0_dest;
      grant_data = vc0_head;
      // The counter only tracks VC0 wins that made VC1 wait; an
      // uncontested VC0 grant restarts the count.
      if (vc1_eligible)
        next_weight_cnt = (weight_cnt < WEIGHT_C) ? weight_cnt + 1'b1 : WEIGHT_C;
      else
        next_weight_cnt = '0;
    end else if (grant_vc1) begin
      grant_dest      = vc1_dest;
      grant_data      = vc1_head;
      next_weight_cnt = '0;
    end
  end

endmodule : vc_arb_select

// File: rtl/vc_arbiter.sv
// ---------------------------------------------------------------------------
// vc_arbiter
//   Transmit-side scheduler moving words from two virtual-channel FIFOs
//   (VC0, VC1) into two destination FIFOs (D0, D1). VC0 is weighted: it
//   may take up to WEIGHT consecutive grants while VC1 waits. Each grant is
//   followed by a WAIT bubble so the source FIFO's registered head can
//   advance, giving at most one word every two cycles.
//
//   Ports:
//     clk             in  system clock, rising edge
//     reset           in  asynchronous active-high reset
//     init            in  0 holds the FSM in IDLE with outputs cleared
//     vc0_empty/vc1_empty         in  VC FIFO empty flags
//     vc0_head/vc1_head           in  VC FIFO head words
//     d0_almost_full/d1_almost_full in destination back-pressure
//     vc0_pop/vc1_pop             out one-cycle VC read enables
//     d0_push/d1_push             out one-cycle destination write enables
//     data_out                    out word being pushed, 0 otherwise
//     active                      out 1 whenever the FSM is not IDLE
//   All outputs are registered.
// ---------------------------------------------------------------------------
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEST_BIT   = DEFAULT_DEST_BIT,
  parameter int WEIGHT     = 3   // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_head,
  input  logic [DATA_WIDTH-1:0] vc1_head,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  active
);

  arb_state_t                  state;
  logic [WEIGHT_CNT_WIDTH-1:0] weight_cnt;

  logic                        grant_vc0;
  logic                        grant_vc1;
  logic                        grant_dest;
  logic [DATA_WIDTH-1:0]       grant_data;
  logic [WEIGHT_CNT_WIDTH-1:0] next_weight_cnt;

  vc_arb_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEST_BIT   (DEST_BIT),
    .WEIGHT     (WEIGHT)
  ) u_select (
    .vc0_empty       (vc0_empty),
    .vc1_empty       (vc1_empty),
    .vc0_head        (vc0_head),
    .vc1_head        (vc1_head),
    .d0_almost_full  (d0_almost_full),
    .d1_almost_full  (d1_almost_full),
    .weight_cnt      (weight_cnt),
    .grant_vc0       (grant_vc0),
    .grant_vc1       (grant_vc1),
    .grant_dest      (grant_dest),
    .grant_data      (grant_data),
    .next_weight_cnt (next_weight_cnt)
  );

  // NOTE: all state and output registers use non-blocking assignments so
  // every register samples pre-edge values and ordering within the block
  // cannot change behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      weight_cnt <= '0;
      vc0_pop    <= 1'b0;
      vc1_pop    <= 1'b0;
      d0_push    <= 1'b0;
      d1_push    <= 1'b0;
      data_out   <= '0;
      active     <= 1'b0;
    end else if (!init) begin
      // Synchronous hold: any strobe already on the outputs lives out its
      // cycle and is cleared here.
      state      <= IDLE;
      weight_cnt <= '0;
      vc0_pop    <= 1'b0;
      vc1_pop    <= 1'b0;
      d0_push    <= 1'b0;
      d1_push    <= 1'b0;
      data_out   <= '0;
      active     <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless a grant is issued below.
      vc0_pop  <= 1'b0;
      vc1_pop  <= 1'b0;
      d0_push  <= 1'b0;
      d1_push  <= 1'b0;
      data_out <= '0;
      // With init high every successor state is ARB or WAIT.
      active   <= 1'b1;

      case (state)
        IDLE: begin
          state <= ARB;
        end
        ARB: begin
          if (grant_vc0 || grant_vc1) begin
            vc0_pop    <= grant_vc0;
            vc1_pop    <= grant_vc1;
            d0_push    <= !grant_dest;
            d1_push    <= grant_dest;
            data_out   <= grant_data;
            weight_cnt <= next_weight_cnt;
            state      <= WAIT;
          end
        end
        WAIT: begin
          state <= ARB;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : vc_arbiter

// File: tb/tb_vc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vc_arbiter
//   Directed bench for vc_arbiter. Queues stand in for the VC FIFOs; the
//   expected grant stream (source VC, destination, word) is pushed to a
//   scoreboard when a scenario is set up and popped whenever the DUT pops.
// ---------------------------------------------------------------------------
module tb_vc_arbiter;

  localparam int DW = 6;

  typedef struct {
    logic          vc;
    logic          dest;
    logic [DW-1:0] data;
  } grant_t;

  logic          clk;
  logic          reset;
  logic          init;
  logic          vc0_empty;
  logic          vc1_empty;
  logic [DW-1:0] vc0_head;
  logic [DW-1:0] vc1_head;
  logic          d0_almost_full;
  logic          d1_almost_full;
  logic          vc0_pop;
  logic          vc1_pop;
  logic          d0_push;
  logic          d1_push;
  logic [DW-1:0] data_out;
  logic          active;

  vc_arbiter #(
    .DATA_WIDTH (DW),
    .DEST_BIT   (4),
    .WEIGHT     (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_head       (vc0_head),
    .vc1_head       (vc1_head),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .vc0_pop        (vc0_pop),
    .vc1_pop        (vc1_pop),
    .d0_push        (d0_push),
    .d1_push        (d1_push),
    .data_out       (data_out),
    .active         (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];
  grant_t        sb[$];
  int            grant_cycles[$];
  int            cyc;
  int            n_tests;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    vc0_empty = (vc0_q.size() == 0);
    vc1_empty = (vc1_q.size() == 0);
    vc0_head  = vc0_empty ? '0 : vc0_q[0];
    vc1_head  = vc1_empty ? '0 : vc1_q[0];
  endtask

  task automatic expect_grant(input logic vc, input logic [DW-1:0] data);
    grant_t g;
    g.vc   = vc;
    g.dest = data[4];
    g.data = data;
    sb.push_back(g);
  endtask

  // One clock: sample just after the edge, score any grant, advance the
  // FIFO model, then re-drive the heads.
  task automatic tick();
    grant_t e;
    @(posedge clk);
    #1;
    cyc++;
    check("never_two_pops", {31'd0, vc0_pop & vc1_pop}, 32'd0);
    if (vc0_pop || vc1_pop) begin
      check("one_push_per_pop", {30'd0, d0_push, d1_push}, d1_push ? 32'd1 : 32'd2);
      if (sb.size() == 0) begin
        check("unexpected_grant", {30'd0, vc0_pop, vc1_pop}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("grant_vc",   {31'd0, vc1_pop}, {31'd0, e.vc});
        check("grant_dest", {31'd0, d1_push}, {31'd0, e.dest});
        check("grant_data", {26'd0, data_out}, {26'd0, e.data});
      end
      grant_cycles.push_back(cyc);
      if (vc0_pop && vc0_q.size() > 0) void'(vc0_q.pop_front());
      if (vc1_pop && vc1_q.size() > 0) void'(vc1_q.pop_front());
    end else begin
      check("no_grant_quiet", {24'd0, d0_push, d1_push, data_out}, 32'd0);
    end
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", sb.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {22'd0, vc0_pop, vc1_pop, d0_push, d1_push, data_out}, 32'd0);
  endtask

  initial begin
    int c0;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset          = 1'b1;
    init           = 1'b0;
    d0_almost_full = 1'b0;
    d1_almost_full = 1'b0;
    drive_inputs();

    // Reset state, then init held low for 5 clocks.
    #12;
    check_all_zero("reset_outputs");
    check("reset_active", {31'd0, active}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("init_low_active", {31'd0, active}, 32'd0);
    end

    // Single VC, single destination: grants 2, 4, 6 edges after init rises.
    vc0_q.push_back(6'h01);
    vc0_q.push_back(6'h0A);
    vc0_q.push_back(6'h0F);
    expect_grant(1'b0, 6'h01);
    expect_grant(1'b0, 6'h0A);
    expect_grant(1'b0, 6'h0F);
    drive_inputs();
    grant_cycles.delete();
    init = 1'b1;
    c0 = cyc;
    tick();
    check("active_after_init", {31'd0, active}, 32'd1);
    drain(12);
    check("single_grant_count", grant_cycles.size(), 32'd3);
    if (grant_cycles.size() == 3) begin
      check("single_cycle_1", grant_cycles[0] - c0, 32'd2);
      check("single_cycle_2", grant_cycles[1] - c0, 32'd4);
      check("single_cycle_3", grant_cycles[2] - c0, 32'd6);
    end

    // Weighting: VC0 x3, VC1, VC0 x3, VC1 with both VCs loaded throughout.
    init = 1'b0;
    tick();
    init = 1'b1;
    tick();
    vc0_q = '{6'h01, 6'h12, 6'h03, 6'h14, 6'h05, 6'h16};
    vc1_q = '{6'h21, 6'h32};
    expect_grant(1'b0, 6'h01);
    expect_grant(1'b0, 6'h12);
    expect_grant(1'b0, 6'h03);
    expect_grant(1'b1, 6'h21);
    expect_grant(1'b0, 6'h14);
    expect_grant(1'b0, 6'h05);
    expect_grant(1'b0, 6'h16);
    expect_grant(1'b1, 6'h32);
    drive_inputs();
    drain(24);

    // Back-pressure: VC0 targets full D1, VC1 targets D0.
    d1_almost_full = 1'b1;
    vc0_q = '{6'h12};
    vc1_q = '{6'h03, 6'h05};
    expect_grant(1'b1, 6'h03);
    expect_grant(1'b1, 6'h05);
    drive_inputs();
    drain(8);
    for (int i = 0; i < 4; i++) tick();
    check("blocked_vc0_waiting", vc0_q.size(), 32'd1);
    d1_almost_full = 1'b0;
    expect_grant(1'b0, 6'h12);
    drain(1);

    // Routing: head 6'b010101 goes to D1.
    tick();
    vc1_q = '{6'h15};
    expect_grant(1'b1, 6'h15);
    drive_inputs();
    drain(4);

    // No eligible source for 10 clocks.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_arb_active", {31'd0, active}, 32'd1);
    end

    // Reset asserted while a grant is on the outputs.
    vc0_q = '{6'h07};
    expect_grant(1'b0, 6'h07);
    drive_inputs();
    drain(4);
    check("grant_visible", {31'd0, vc0_pop}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset_outputs");
    check("async_reset_active", {31'd0, active}, 32'd0);
    #1;
    reset = 1'b0;

    // init dropped while a grant is on the outputs: cleared on the next edge.
    vc1_q = '{6'h09};
    expect_grant(1'b1, 6'h09);
    drive_inputs();
    drain(6);
    init = 1'b0;
    tick();
    check("init_drop_active", {31'd0, active}, 32'd0);
    check_all_zero("init_drop_outputs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vc_arbiter
